// File: rtl/bspline_interp_mc.sv
`default_nettype none
// ============================================================================
//  Module      : bspline_interp_mc
//  Description : Multi-channel cubic uniform B-spline interpolator.
//                Control points arrive over valid/ready. Each segment yields
//                2^LOG2_R samples per channel from forward-difference
//                accumulators. Outputs are shift-scaled and saturated.
//  Revision    : 1.0 - initial release
// ============================================================================
module bspline_interp_mc #(
    parameter int CH        = 2,
    parameter int DIN_W     = 7,
    parameter int DOUT_W    = 14,
    parameter int LOG2_R    = 3,
    parameter int STEP_DIV  = 1,
    parameter int OUT_SHIFT = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CH*DIN_W-1:0]  din,
    output logic                 out_valid,
    output logic [CH*DOUT_W-1:0] dout,
    output logic                 underrun
);
    localparam int ACC_W  = DIN_W + 3*LOG2_R + 7;
    localparam int TICK_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    localparam logic [1:0] S_FILL = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    localparam logic [LOG2_R-1:0] K_LAST    = '1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(STEP_DIV - 1);

    localparam logic signed [ACC_W-1:0] C3      = ACC_W'(3);
    localparam logic signed [ACC_W-1:0] C4      = ACC_W'(4);
    localparam logic signed [ACC_W-1:0] C6      = ACC_W'(6);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2**(DOUT_W-1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    logic [1:0]        state_q, state_d;
    logic [1:0]        fill_cnt_q, fill_cnt_d;
    logic [LOG2_R-1:0] k_q, k_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic              nxt_full_q, nxt_full_d;
    logic              underrun_q, underrun_d;
    logic              out_valid_q, out_valid_d;

    logic w_accept, w_fire, w_last, w_fill_done, w_roll, w_wait_go;
    logic w_load, w_shift_win, w_use_din;

    assign in_ready    = (state_q == S_FILL) || !nxt_full_q;
    assign w_accept    = in_valid && in_ready;
    assign w_fire      = (state_q == S_RUN) && (tick_q == TICK_LAST);
    assign w_last      = w_fire && (k_q == K_LAST);
    assign w_fill_done = (state_q == S_FILL) && w_accept && (fill_cnt_q == 2'd3);
    // A point accepted on the last sample is consumed directly: no gap cycle.
    assign w_roll      = w_last && (nxt_full_q || w_accept);
    assign w_wait_go   = (state_q == S_WAIT) && nxt_full_q;
    assign w_load      = w_fill_done || w_roll || w_wait_go;
    assign w_shift_win = ((state_q == S_FILL) && w_accept) || w_roll || w_wait_go;
    assign w_use_din   = (state_q == S_FILL) || !nxt_full_q;

    assign out_valid = out_valid_q;
    assign underrun  = underrun_q;

    // Sequencing: fill count, sample cadence, segment rollover and prefetch flag.
    always_comb begin
        state_d     = state_q;
        fill_cnt_d  = fill_cnt_q;
        k_d         = k_q;
        tick_d      = tick_q;
        nxt_full_d  = nxt_full_q;
        underrun_d  = underrun_q;
        out_valid_d = 1'b0;
        case (state_q)
            S_FILL: begin
                if (w_accept) begin
                    fill_cnt_d = fill_cnt_q + 2'd1;
                    if (w_fill_done) begin
                        state_d = S_RUN;
                        k_d     = '0;
                        tick_d  = '0;
                    end
                end
            end
            S_RUN: begin
                if (w_accept) nxt_full_d = 1'b1;
                if (w_fire) begin
                    out_valid_d = 1'b1;
                    tick_d      = '0;
                    k_d         = k_q + 1'b1;
                    if (w_last) begin
                        if (w_roll) nxt_full_d = 1'b0;
                        else        state_d    = S_WAIT;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            S_WAIT: begin
                underrun_d = 1'b1;
                if (w_accept) nxt_full_d = 1'b1;
                if (w_wait_go) begin
                    nxt_full_d = 1'b0;
                    state_d    = S_RUN;
                    k_d        = '0;
                    tick_d     = '0;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FILL;
            fill_cnt_q  <= 2'd0;
            k_q         <= '0;
            tick_q      <= '0;
            nxt_full_q  <= 1'b0;
            underrun_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            k_q         <= k_d;
            tick_q      <= tick_d;
            nxt_full_q  <= nxt_full_d;
            underrun_q  <= underrun_d;
            out_valid_q <= out_valid_d;
        end
    end

    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
        // Only P1..P3 of the active window are kept: once coefficients are
        // loaded, P0 is never needed again.
        logic signed [DIN_W-1:0]  win1_q, win2_q, win3_q, nxt_q;
        logic signed [DIN_W-1:0]  win1_d, win2_d, win3_d, nxt_d;
        logic signed [ACC_W-1:0]  f_q, d1_q, d2_q, d3_q;
        logic signed [ACC_W-1:0]  f_d, d1_d, d2_d, d3_d;
        logic signed [DOUT_W-1:0] dout_q, dout_d;
        logic signed [DIN_W-1:0]  w_din, w_src;
        logic signed [ACC_W-1:0]  w_e0, w_e1, w_e2, w_e3;
        logic signed [ACC_W-1:0]  w_a, w_b, w_c, w_d, w_sh;

        assign w_din = din[gi*DIN_W +: DIN_W];
        assign w_src = w_use_din ? w_din : nxt_q;

        // Window becoming active is {P1, P2, P3, incoming}.
        assign w_e0 = {{(ACC_W-DIN_W){win1_q[DIN_W-1]}}, win1_q};
        assign w_e1 = {{(ACC_W-DIN_W){win2_q[DIN_W-1]}}, win2_q};
        assign w_e2 = {{(ACC_W-DIN_W){win3_q[DIN_W-1]}}, win3_q};
        assign w_e3 = {{(ACC_W-DIN_W){w_src[DIN_W-1]}},  w_src};

        assign w_a  = (w_e3 - w_e0) + C3 * (w_e1 - w_e2);
        assign w_b  = C3 * (w_e0 + w_e2) - C6 * w_e1;
        assign w_c  = C3 * (w_e2 - w_e0);
        assign w_d  = w_e0 + w_e2 + C4 * w_e1;
        assign w_sh = f_q >>> OUT_SHIFT;

        // Window shift, prefetch capture, accumulator load/advance, saturation.
        always_comb begin
            win1_d = win1_q;
            win2_d = win2_q;
            win3_d = win3_q;
            nxt_d  = nxt_q;
            f_d    = f_q;
            d1_d   = d1_q;
            d2_d   = d2_q;
            d3_d   = d3_q;
            dout_d = dout_q;
            if (w_shift_win) begin
                win1_d = win2_q;
                win2_d = win3_q;
                win3_d = w_src;
            end
            if (w_accept) nxt_d = w_din;
            if (w_load) begin
                f_d  = w_d <<< (3*LOG2_R);
                d1_d = w_a + (w_b <<< LOG2_R) + (w_c <<< (2*LOG2_R));
                d2_d = C6 * w_a + (w_b <<< (LOG2_R + 1));
                d3_d = C6 * w_a;
            end else if (w_fire) begin
                f_d  = f_q + d1_q;
                d1_d = d1_q + d2_q;
                d2_d = d2_q + d3_q;
            end
            if (w_fire) begin
                if (w_sh > SAT_MAX)      dout_d = SAT_MAX[DOUT_W-1:0];
                else if (w_sh < SAT_MIN) dout_d = SAT_MIN[DOUT_W-1:0];
                else                     dout_d = w_sh[DOUT_W-1:0];
            end
        end

        // Per-channel datapath registers.
        always_ff @(posedge clk) begin
            if (rst) begin
                win1_q <= '0;
                win2_q <= '0;
                win3_q <= '0;
                nxt_q  <= '0;
                f_q    <= '0;
                d1_q   <= '0;
                d2_q   <= '0;
                d3_q   <= '0;
                dout_q <= '0;
            end else begin
                win1_q <= win1_d;
                win2_q <= win2_d;
                win3_q <= win3_d;
                nxt_q  <= nxt_d;
                f_q    <= f_d;
                d1_q   <= d1_d;
                d2_q   <= d2_d;
                d3_q   <= d3_d;
                dout_q <= dout_d;
            end
        end

        assign dout[gi*DOUT_W +: DOUT_W] = dout_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_bspline_interp_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bspline_interp_mc
//  Description : Directed self-checking bench for bspline_interp_mc.
//                Instance A uses default parameters; instance B runs with
//                STEP_DIV=4 and OUT_SHIFT=3 for cadence and saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bspline_interp_mc;
    localparam int CH     = 2;
    localparam int DIN_W  = 7;
    localparam int DOUT_W = 14;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_a, in_valid_a, in_ready_a, out_valid_a, underrun_a;
    logic [CH*DIN_W-1:0]  din_a;
    logic [CH*DOUT_W-1:0] dout_a;
    logic                 rst_b, in_valid_b, in_ready_b, out_valid_b, underrun_b;
    logic [CH*DIN_W-1:0]  din_b;
    logic [CH*DOUT_W-1:0] dout_b;

    int n_cmp = 0;
    int n_err = 0;

    bspline_interp_mc dut_a (
        .clk       (clk),
        .rst       (rst_a),
        .in_valid  (in_valid_a),
        .in_ready  (in_ready_a),
        .din       (din_a),
        .out_valid (out_valid_a),
        .dout      (dout_a),
        .underrun  (underrun_a)
    );

    bspline_interp_mc #(
        .STEP_DIV  (4),
        .OUT_SHIFT (3)
    ) dut_b (
        .clk       (clk),
        .rst       (rst_b),
        .in_valid  (in_valid_b),
        .in_ready  (in_ready_b),
        .din       (din_b),
        .out_valid (out_valid_b),
        .dout      (dout_b),
        .underrun  (underrun_b)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CH*DIN_W-1:0] pack(input int c0, input int c1);
        logic [CH*DIN_W-1:0] r;
        r[DIN_W-1:0]       = DIN_W'(c0);
        r[2*DIN_W-1:DIN_W] = DIN_W'(c1);
        return r;
    endfunction

    function automatic logic signed [31:0] ch0(input logic [CH*DOUT_W-1:0] v);
        return 32'($signed(v[DOUT_W-1:0]));
    endfunction

    function automatic logic signed [31:0] ch1(input logic [CH*DOUT_W-1:0] v);
        return 32'($signed(v[2*DOUT_W-1:DOUT_W]));
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    initial begin
        rst_a = 1'b1; in_valid_a = 1'b0; din_a = '0;
        rst_b = 1'b1; in_valid_b = 1'b0; din_b = '0;
        step();
        step();

        // ---- reset state ----
        chk("rst_dout0",     ch0(dout_a), 0);
        chk("rst_dout1",     ch1(dout_a), 0);
        chk("rst_out_valid", out_valid_a, 0);
        chk("rst_underrun",  underrun_a,  0);
        chk("rst_in_ready",  in_ready_a,  1);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // ---- constant fill: 10 / -64, gain 96 ----
        din_a = pack(10, -64);
        in_valid_a = 1'b1;
        for (int i = 1; i <= 4; i++) step();
        chk("const_no_early_valid", out_valid_a, 0);
        chk("const_ready_run",      in_ready_a,  1);
        step();                             // 5th point goes to prefetch
        in_valid_a = 1'b0;
        chk("const_first_valid", out_valid_a, 1);
        chk("const_first_ch0",   ch0(dout_a), 960);
        chk("const_first_ch1",   ch1(dout_a), -6144);
        chk("const_ready_full",  in_ready_a,  0);
        for (int i = 6; i <= 20; i++) begin
            step();
            chk("const_valid", out_valid_a, 1);
            chk("const_ch0",   ch0(dout_a), 960);
            chk("const_ch1",   ch1(dout_a), -6144);
            if (i == 10) chk("const_no_underrun", underrun_a, 0);
        end

        // ---- underrun: no more points ----
        step();
        chk("udr_valid_low", out_valid_a, 0);
        step();
        chk("udr_flag",       underrun_a,  1);
        chk("udr_valid_low2", out_valid_a, 0);
        chk("udr_hold_ch0",   ch0(dout_a), 960);
        chk("udr_hold_ch1",   ch1(dout_a), -6144);
        step();
        in_valid_a = 1'b1;
        din_a = pack(10, -64);
        step();                             // accepted into prefetch in WAIT
        in_valid_a = 1'b0;
        chk("resume_wait0", out_valid_a, 0);
        step();
        chk("resume_wait1", out_valid_a, 0);
        step();
        chk("resume_valid", out_valid_a, 1);
        chk("resume_ch0",   ch0(dout_a), 960);
        chk("resume_sticky", underrun_a, 1);

        // ---- reset mid-RUN at k=3 ----
        step();                             // k=1
        step();                             // k=2
        rst_a = 1'b1;
        step();
        chk("mrst_dout0",    ch0(dout_a), 0);
        chk("mrst_dout1",    ch1(dout_a), 0);
        chk("mrst_valid",    out_valid_a, 0);
        chk("mrst_underrun", underrun_a,  0);
        chk("mrst_ready",    in_ready_a,  1);
        rst_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("mrst_quiet", out_valid_a, 0);
        end

        // ---- ramp 0,8,16,24 (+32 prefetched) on ch0, constant -10 on ch1 ----
        in_valid_a = 1'b1;
        din_a = pack(0, -10);  step();
        din_a = pack(8, -10);  step();
        din_a = pack(16, -10); step();
        din_a = pack(24, -10); step();
        chk("ramp_no_early_valid", out_valid_a, 0);
        din_a = pack(32, -10); step();
        in_valid_a = 1'b0;
        for (int j = 0; j < 16; j++) begin
            if (j > 0) step();
            chk("ramp_valid", out_valid_a, 1);
            chk("ramp_ch0",   ch0(dout_a), 768 + 96*j);
            chk("ramp_ch1",   ch1(dout_a), -960);
        end
        step();
        chk("ramp_end_valid", out_valid_a, 0);

        // ---- cadence, handshake and saturation on instance B ----
        in_valid_b = 1'b1;
        din_b = pack(63, -64);
        for (int i = 1; i <= 76; i++) begin
            logic exp_ov;
            logic exp_rdy;
            step();
            exp_ov  = (i >= 8) && (i % 4 == 0);
            exp_rdy = (i <= 4) || (i % 32 == 4);
            chk("cad_valid", out_valid_b, 32'(exp_ov));
            chk("cad_ready", in_ready_b,  32'(exp_rdy));
            if (exp_ov) begin
                chk("sat_ch0", ch0(dout_b), 8191);
                chk("sat_ch1", ch1(dout_b), -8192);
            end
        end
        chk("cad_no_underrun", underrun_b, 0);
        in_valid_b = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
